// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a small byte FIFO feeding a baud-timed shift register.
// Frames are sent back-to-back while the FIFO holds data; uart_txd is a registered output.
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int UART_BPS   = 128000,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst,
    input  logic                          wr_en,
    input  logic [7:0]                    wr_data,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow,
    output logic                          tx_busy,
    output logic                          tx_done,
    output logic                          uart_txd
);

    localparam int BPS_CNT = CLK_FREQ / UART_BPS;
    localparam int CW      = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int LW      = AW + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic [7:0]    head;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    shift, shift_n;
    logic          txd_n;
    logic          busy_n;
    logic          done_n;
    logic          bit_end;

    // Full is judged on the registered level, so a pop in the same cycle cannot rescue a write.
    assign push = wr_en && !full;
    assign full = (level == LW'(FIFO_DEPTH));
    assign head = mem[rd_ptr];

    always_ff @(posedge sys_clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    assign bit_end = (cnt == CW'(BPS_CNT - 1));

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= '0;
            shift    <= '0;
            uart_txd <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            idx      <= idx_n;
            shift    <= shift_n;
            uart_txd <= txd_n;
            tx_busy  <= busy_n;
            tx_done  <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shift_n = shift;
        txd_n   = uart_txd;
        busy_n  = tx_busy;
        done_n  = 1'b0;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                txd_n = 1'b1;
                if (level != '0) begin
                    pop     = 1'b1;
                    shift_n = head;
                    txd_n   = 1'b0;
                    busy_n  = 1'b1;
                    cnt_n   = '0;
                    state_n = START;
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    txd_n   = shift[0];
                    state_n = DATA;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_n = '0;
                    if (idx == 3'd7) begin
                        txd_n   = 1'b1;
                        state_n = STOP;
                    end else begin
                        idx_n = idx + 1'b1;
                        txd_n = shift[idx_n];
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_n  = '0;
                    done_n = 1'b1;
                    // Chain straight into the next start bit so queued frames leave no idle gap.
                    if (level != '0) begin
                        pop     = 1'b1;
                        shift_n = head;
                        txd_n   = 1'b0;
                        state_n = START;
                    end else begin
                        busy_n  = 1'b0;
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                txd_n   = 1'b1;
                busy_n  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: writes push expected bytes, a line monitor decodes
// frames from uart_txd and pops/compares them, with directed timing checks in the main thread.
module tb_uart_tx_fifo;

    localparam int LW = 5;

    logic          sys_clk = 1'b0;
    logic          sys_rst;
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          full;
    logic [LW-1:0] level;
    logic          overflow;
    logic          tx_busy;
    logic          tx_done;
    logic          uart_txd;

    uart_tx_fifo #(
        .CLK_FREQ   (1000),
        .UART_BPS   (100),
        .FIFO_DEPTH (16)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .level    (level),
        .overflow (overflow),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done),
        .uart_txd (uart_txd)
    );

    always #5 sys_clk = ~sys_clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    logic [7:0] exp_q[$];
    int         starts_q[$];
    int         done_cnt = 0;
    int         last_done_cyc = 0;
    logic       busy_at_done = 1'b1;
    int         peak = 0;
    bit         mon_active = 1'b0;
    int         mon_cnt = 0;
    logic [7:0] mon_byte = '0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Line monitor: counts negedges from the first low sample and samples each bit mid-period.
    always @(negedge sys_clk) begin
        if (sys_rst) begin
            mon_active = 1'b0;
        end else if (!mon_active) begin
            if (uart_txd === 1'b0) begin
                mon_active = 1'b1;
                mon_cnt    = 0;
                starts_q.push_back(cyc);
            end
        end else begin
            mon_cnt++;
            if (mon_cnt == 4) begin
                check("start_bit", {31'd0, uart_txd}, 32'd0);
            end else if (mon_cnt >= 14 && mon_cnt <= 84 && (mon_cnt - 14) % 10 == 0) begin
                mon_byte[(mon_cnt - 14) / 10] = uart_txd;
            end else if (mon_cnt == 94) begin
                check("stop_bit", {31'd0, uart_txd}, 32'd1);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL frame_data: got unexpected byte %02h, expected no frame", mon_byte);
                end else begin
                    check("frame_data", {24'd0, mon_byte}, {24'd0, exp_q.pop_front()});
                end
                mon_active = 1'b0;
            end
        end
    end

    always @(negedge sys_clk) begin
        if (!sys_rst && tx_done === 1'b1) begin
            done_cnt++;
            last_done_cyc = cyc;
            busy_at_done  = tx_busy;
        end
        if (!sys_rst && int'(level) > peak) peak = int'(level);
    end

    task automatic wait_drain(input int max_cycles);
        bit drained;
        drained = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge sys_clk);
            if (exp_q.size() == 0 && !tx_busy && !mon_active) begin
                drained = 1'b1;
                break;
            end
        end
        check("drain_within_budget", {31'd0, drained}, 32'd1);
        repeat (3) @(negedge sys_clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, expected finish before 1ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         d0;
        bit         hi;
        logic [9:0] sb_wave;
        logic [7:0] b2b[3];
        logic [7:0] ov[18];
        logic [7:0] mr[6];

        sb_wave = 10'b10_1010_1010;
        b2b = '{8'hA5, 8'h3C, 8'hFF};
        ov  = '{8'h01, 8'h80, 8'h7E, 8'hC3, 8'h00, 8'hFF, 8'h5A, 8'h12,
                8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h0F, 8'h99, 8'hEE};
        mr  = '{8'h08, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

        // Reset with random write traffic
        sys_rst = 1'b1;
        wr_en   = 1'b0;
        wr_data = '0;
        repeat (8) begin
            @(negedge sys_clk);
            wr_en   = 1'($urandom_range(0, 1));
            wr_data = 8'($urandom);
        end
        @(negedge sys_clk);
        check("rst_txd",      {31'd0, uart_txd}, 32'd1);
        check("rst_busy",     {31'd0, tx_busy},  32'd0);
        check("rst_done",     {31'd0, tx_done},  32'd0);
        check("rst_level",    {27'd0, level},    32'd0);
        check("rst_full",     {31'd0, full},     32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        wr_en   = 1'b0;
        sys_rst = 1'b0;
        repeat (3) @(negedge sys_clk);
        check("idle_line", {31'd0, uart_txd}, 32'd1);

        // Single byte 0x55
        d0 = done_cnt;
        starts_q.delete();
        wr_en   = 1'b1;
        wr_data = 8'h55;
        exp_q.push_back(8'h55);
        @(negedge sys_clk);
        wr_en = 1'b0;
        check("sb_level_after_push", {27'd0, level}, 32'd1);
        @(negedge sys_clk);
        check("sb_txd_fall",         {31'd0, uart_txd}, 32'd0);
        check("sb_busy_rise",        {31'd0, tx_busy},  32'd1);
        check("sb_level_after_pop",  {27'd0, level},    32'd0);
        repeat (5) @(negedge sys_clk);
        for (int k = 0; k < 10; k++) begin
            check($sformatf("sb_wave_bit%0d", k), {31'd0, uart_txd}, {31'd0, sb_wave[k]});
            if (k < 9) repeat (10) @(negedge sys_clk);
        end
        repeat (10) @(negedge sys_clk);
        check("sb_done_count",   done_cnt - d0, 32'd1);
        check("sb_frame_count",  starts_q.size(), 32'd1);
        check("sb_done_latency", last_done_cyc - starts_q[0], 32'd100);
        check("sb_busy_fall",    {31'd0, busy_at_done}, 32'd0);

        // Back-to-back bytes
        d0 = done_cnt;
        starts_q.delete();
        peak = 0;
        for (int i = 0; i < 3; i++) begin
            wr_en   = 1'b1;
            wr_data = b2b[i];
            exp_q.push_back(b2b[i]);
            @(negedge sys_clk);
        end
        wr_en = 1'b0;
        wait_drain(400);
        check("b2b_done_count",  done_cnt - d0, 32'd3);
        check("b2b_frame_count", starts_q.size(), 32'd3);
        check("b2b_gap_1_2",     starts_q[1] - starts_q[0], 32'd100);
        check("b2b_gap_2_3",     starts_q[2] - starts_q[1], 32'd100);
        check("b2b_total",       last_done_cyc - starts_q[0], 32'd300);
        check("b2b_level_peak",  peak, 32'd2);

        // Overflow: 18 consecutive writes, the last one dropped
        d0 = done_cnt;
        for (int i = 0; i < 18; i++) begin
            wr_en   = 1'b1;
            wr_data = ov[i];
            if (i < 17) exp_q.push_back(ov[i]);
            @(negedge sys_clk);
            if (i == 16) begin
                check("ov_level_w17",    {27'd0, level},    32'd16);
                check("ov_full_w17",     {31'd0, full},     32'd1);
                check("ov_overflow_w17", {31'd0, overflow}, 32'd0);
            end else if (i == 17) begin
                check("ov_level_w18",    {27'd0, level},    32'd16);
                check("ov_full_w18",     {31'd0, full},     32'd1);
                check("ov_overflow_w18", {31'd0, overflow}, 32'd1);
            end
        end
        wr_en = 1'b0;
        wait_drain(2000);
        check("ov_done_count",   done_cnt - d0, 32'd17);
        check("ov_sticky",       {31'd0, overflow}, 32'd1);
        check("ov_level_drained", {27'd0, level},   32'd0);
        check("ov_full_drained",  {31'd0, full},    32'd0);

        // Reset mid-frame during data bit 3 with level 5
        for (int i = 0; i < 6; i++) begin
            wr_en   = 1'b1;
            wr_data = mr[i];
            exp_q.push_back(mr[i]);
            @(negedge sys_clk);
        end
        wr_en = 1'b0;
        check("mr_level_5", {27'd0, level}, 32'd5);
        repeat (41) @(negedge sys_clk);
        check("mr_in_bit3", {31'd0, uart_txd}, 32'd1);
        #2;
        sys_rst = 1'b1;
        #1;
        check("mr_txd_async", {31'd0, uart_txd}, 32'd1);
        check("mr_level",     {27'd0, level},    32'd0);
        check("mr_busy",      {31'd0, tx_busy},  32'd0);
        check("mr_overflow",  {31'd0, overflow}, 32'd0);
        exp_q.delete();
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        d0 = done_cnt;
        starts_q.delete();
        hi = 1'b1;
        repeat (300) begin
            @(negedge sys_clk);
            if (uart_txd !== 1'b1) hi = 1'b0;
        end
        check("mr_line_high",   {31'd0, hi},       32'd1);
        check("mr_no_frames",   starts_q.size(),   32'd0);
        check("mr_no_done",     done_cnt - d0,     32'd0);
        check("mr_level_after", {27'd0, level},    32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
